// File: rtl/xor_meter_pkg.sv
// ---------------------------------------------------------------------------
// xor_meter_pkg
// Shared definitions for the XOR pulse meter: FSM state type and encodings,
// and the minimum synchronizer depth allowed on the asynchronous XOR input.
// ---------------------------------------------------------------------------
package xor_meter_pkg;

    // Minimum number of flops between the asynchronous xor_in and any logic.
    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meter_state_e;

endpackage : xor_meter_pkg

// File: rtl/xm_sync.sv
// ---------------------------------------------------------------------------
// xm_sync
// N-flop synchronizer for a single asynchronous bit.
//
// Parameters:
//   STAGES : number of flops in the chain (>= 2)
// Ports:
//   clk_i  : destination clock (rising edge)
//   rst_ni : synchronous active-low reset, clears every flop
//   d_i    : asynchronous input
//   q_o    : synchronized output (last flop of the chain)
// ---------------------------------------------------------------------------
module xm_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : xm_sync

// File: rtl/xor_pulse_meter.sv
// ---------------------------------------------------------------------------
// xor_pulse_meter
// Measures the asynchronous XOR output of a dual inverter-chain stage over a
// programmable window: counts sampled-high cycles and (optionally) rising
// edges of the synchronized signal, with saturating counters and a sticky
// overflow flag. Results are offered through a valid/ready handshake.
//
// Optional feature macro:
//   XOR_METER_EDGE_CNT_EN : when defined, edge_count is implemented; when
//                           undefined, edge_count is tied to 0 and overflow
//                           reflects hi_count only.
//
// Parameters:
//   CNT_W       : width of hi_count / edge_count
//   WIN_W       : width of window_len
//   SYNC_STAGES : synchronizer depth on xor_in (minimum 2)
// Ports:
//   sys_clk      : the only clock, rising edge
//   sys_rst_n    : synchronous active-low reset
//   xor_in       : asynchronous input being measured
//   start        : measurement request, only honoured in IDLE
//   window_len   : window length in sys_clk cycles, captured on start
//   busy         : high while arming or measuring
//   result_valid : result available (DONE)
//   result_ready : consumer accepts the result
//   hi_count     : sampled-high cycles in the window
//   edge_count   : rising edges in the window
//   overflow     : a counter saturated during the window
// ---------------------------------------------------------------------------
module xor_pulse_meter
    import xor_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             xor_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] hi_count,
    output logic [CNT_W-1:0] edge_count,
    output logic             overflow
);

    // A too-small depth is clamped up rather than silently accepted.
    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
    localparam int ARM_W  = $clog2(SYNC_N);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_N - 1);

    // Saturating increment: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic xs;

    meter_state_e     state_q, state_d;
    logic [WIN_W-1:0] meas_q,  meas_d;   // remaining MEASURE cycles
    logic [ARM_W-1:0] arm_q,   arm_d;    // cycles spent in ARM
    logic [CNT_W-1:0] hi_q,    hi_d;
    logic             ovf_q,   ovf_d;
`ifdef XOR_METER_EDGE_CNT_EN
    logic [CNT_W-1:0] edge_q,  edge_d;
    logic             prev_q,  prev_d;   // xs of the previous cycle
`endif

    xm_sync #(
        .STAGES (SYNC_N)
    ) u_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (xor_in),
        .q_o    (xs)
    );

    always_comb begin
        state_d = state_q;
        meas_d  = meas_q;
        arm_d   = arm_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;
`ifdef XOR_METER_EDGE_CNT_EN
        edge_d  = edge_q;
        prev_d  = prev_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    meas_d  = window_len;
                    arm_d   = '0;
                    hi_d    = '0;
                    ovf_d   = 1'b0;
`ifdef XOR_METER_EDGE_CNT_EN
                    edge_d  = '0;
`endif
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // Flush the synchronizer; the xs seen in the last ARM cycle
                // is the edge reference for the first MEASURE cycle.
                arm_d = arm_q + 1'b1;
`ifdef XOR_METER_EDGE_CNT_EN
                prev_d = xs;
`endif
                if (arm_q == ARM_LAST) begin
                    state_d = (meas_q == '0) ? ST_DONE : ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                meas_d = meas_q - 1'b1;
                if (xs) begin
                    hi_d = sat_inc(hi_q);
                    if (&hi_q) begin
                        ovf_d = 1'b1;
                    end
                end
`ifdef XOR_METER_EDGE_CNT_EN
                prev_d = xs;
                if (xs && !prev_q) begin
                    edge_d = sat_inc(edge_q);
                    if (&edge_q) begin
                        ovf_d = 1'b1;
                    end
                end
`endif
                if (meas_q == WIN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            meas_q  <= '0;
            arm_q   <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
`ifdef XOR_METER_EDGE_CNT_EN
            edge_q  <= '0;
            prev_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            meas_q  <= meas_d;
            arm_q   <= arm_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
`ifdef XOR_METER_EDGE_CNT_EN
            edge_q  <= edge_d;
            prev_q  <= prev_d;
`endif
        end
    end

    assign busy         = (state_q == ST_ARM) || (state_q == ST_MEASURE);
    assign result_valid = (state_q == ST_DONE);
    assign hi_count     = hi_q;
    assign overflow     = ovf_q;
`ifdef XOR_METER_EDGE_CNT_EN
    assign edge_count   = edge_q;
`else
    assign edge_count   = '0;
`endif

endmodule : xor_pulse_meter

// File: tb/tb_xor_pulse_meter.sv
module tb_xor_pulse_meter;

    localparam int S  = 2;
    localparam int WW = 16;

`ifdef XOR_METER_EDGE_CNT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          sys_clk      = 1'b0;
    logic          sys_rst_n    = 1'b0;
    logic          xor_in       = 1'b0;
    logic          start        = 1'b0;
    logic          result_ready = 1'b0;
    logic [WW-1:0] window_len   = '0;

    logic        busy_a, rv_a, ovf_a;
    logic [15:0] hi_a, edge_a;
    logic        busy_b, rv_b, ovf_b;
    logic [3:0]  hi_b, edge_b;

    xor_pulse_meter #(.CNT_W(16), .WIN_W(WW), .SYNC_STAGES(S)) dut16 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .xor_in(xor_in), .start(start),
        .window_len(window_len), .busy(busy_a), .result_valid(rv_a),
        .result_ready(result_ready), .hi_count(hi_a), .edge_count(edge_a),
        .overflow(ovf_a)
    );

    xor_pulse_meter #(.CNT_W(4), .WIN_W(WW), .SYNC_STAGES(S)) dut4 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .xor_in(xor_in), .start(start),
        .window_len(window_len), .busy(busy_b), .result_valid(rv_b),
        .result_ready(result_ready), .hi_count(hi_b), .edge_count(edge_b),
        .overflow(ovf_b)
    );

    always #5 sys_clk = ~sys_clk;

    // Value of xor_in seen at every rising edge, indexed by edge number.
    bit hist [0:32767];
    int cyc = 0;
    always @(posedge sys_clk) begin
        hist[cyc] <= xor_in;
        cyc       <= cyc + 1;
    end

    int ncmp  = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy16"}, busy_a, 0);
        check({tag, "_rv16"},   rv_a,   0);
        check({tag, "_hi16"},   hi_a,   0);
        check({tag, "_edge16"}, edge_a, 0);
        check({tag, "_ovf16"},  ovf_a,  0);
        check({tag, "_busy4"},  busy_b, 0);
        check({tag, "_rv4"},    rv_b,   0);
        check({tag, "_hi4"},    hi_b,   0);
        check({tag, "_edge4"},  edge_b, 0);
        check({tag, "_ovf4"},   ovf_b,  0);
    endtask

    // mode: 0 = hold init, 1 = toggle every cycle, 2 = random
    task automatic measure(input int w, input int mode, input logic init,
                           input int rd, input string tag);
        int s, n, ehi, eedge, mx16, mx4;
        bit got;
        @(negedge sys_clk);
        xor_in     = init;
        start      = 1'b1;
        window_len = WW'(w);
        @(posedge sys_clk); #1;
        s          = cyc - 1;
        start      = 1'b0;
        window_len = WW'($urandom);   // must not affect the running window
        check({tag, "_busy_arm"}, busy_a, 1);
        got = 1'b0;
        n   = 0;
        while (!got && n < w + S + 20) begin
            @(negedge sys_clk);
            case (mode)
                1:       xor_in = ~xor_in;
                2:       xor_in = 1'($urandom_range(0, 1));
                default: ;
            endcase
            @(posedge sys_clk); #1;
            n++;
            if (rv_a) got = 1'b1;
        end
        check({tag, "_latency"}, got ? n : -1, w + S);
        check({tag, "_rv4"}, rv_b, 1);

        ehi   = 0;
        eedge = 0;
        for (int j = 1; j <= w; j++) begin
            if (hist[s + j]) ehi++;
            if (EDGE_EN && hist[s + j] && !hist[s + j - 1]) eedge++;
        end
        mx16 = 65535;
        mx4  = 15;
        check({tag, "_hi16"},   hi_a,   sat(ehi, 16));
        check({tag, "_edge16"}, edge_a, sat(eedge, 16));
        check({tag, "_ovf16"},  ovf_a,  (ehi > mx16 || eedge > mx16) ? 1 : 0);
        check({tag, "_hi4"},    hi_b,   sat(ehi, 4));
        check({tag, "_edge4"},  edge_b, sat(eedge, 4));
        check({tag, "_ovf4"},   ovf_b,  (ehi > mx4 || eedge > mx4) ? 1 : 0);

        // Consumer stalls; start pulses must be ignored and results held.
        for (int k = 0; k < rd; k++) begin
            @(negedge sys_clk);
            start  = (k == 1);
            xor_in = 1'($urandom_range(0, 1));
            @(posedge sys_clk); #1;
            check({tag, "_hold_rv"},   rv_a,   1);
            check({tag, "_hold_busy"}, busy_a, 0);
            check({tag, "_hold_hi16"}, hi_a,   sat(ehi, 16));
            check({tag, "_hold_hi4"},  hi_b,   sat(ehi, 4));
        end

        // Handshake with a simultaneous start, which must also be ignored.
        @(negedge sys_clk);
        start        = 1'b1;
        result_ready = 1'b1;
        @(posedge sys_clk); #1;
        check({tag, "_hs_rv"},   rv_a,   0);
        check({tag, "_hs_busy"}, busy_a, 0);
        @(negedge sys_clk);
        start        = 1'b0;
        result_ready = 1'b0;
        @(posedge sys_clk); #1;
        check({tag, "_idle_busy"}, busy_a, 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_all_zero("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        measure(100, 0, 1'b1, 0, "hold1_w100");
        measure(20,  0, 1'b1, 2, "hold1_w20");
        measure(10,  1, 1'b0, 5, "toggle_w10");
        measure(0,   2, 1'b1, 5, "w0");

        // Reset pulse in the middle of a measurement.
        @(negedge sys_clk);
        xor_in     = 1'b1;
        start      = 1'b1;
        window_len = WW'(50);
        @(negedge sys_clk);
        start = 1'b0;
        repeat (10) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        check_all_zero("midrst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        measure(12, 2, 1'b0, 1, "after_rst");

        for (int i = 0; i < 6; i++) begin
            measure($urandom_range(0, 40), 2, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule : tb_xor_pulse_meter

// File: doc/xor_pulse_meter.md
XOR_PULSE_METER -- requirements
Module: xor_pulse_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of hi_count and edge_count.
REQ-002 SHALL have parameter WIN_W, default 16: width of window_len.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, minimum 2: synchronizer depth on xor_in.
REQ-004 SHALL have port sys_clk, input, 1: the only clock; all flops on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port xor_in, input, 1: asynchronous XOR output of the dual inverter-chain stage.
REQ-007 SHALL have port start, input, 1: measurement request, sampled only in IDLE.
REQ-008 SHALL have port window_len, input, WIN_W: measurement length in sys_clk cycles, captured on start.
REQ-009 SHALL have port busy, output, 1: high in ARM and MEASURE.
REQ-010 SHALL have port result_valid, output, 1: result available.
REQ-011 SHALL have port result_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port hi_count, output, CNT_W: sampled-high cycles in the window.
REQ-013 SHALL have port edge_count, output, CNT_W: rising edges in the window.
REQ-014 SHALL have port overflow, output, 1: a counter saturated.

Function
REQ-015 SHALL pass xor_in through SYNC_STAGES flops; only the synchronized value (xs) is used.
REQ-016 SHALL implement FSM IDLE -> ARM -> MEASURE -> DONE -> IDLE.
REQ-017 SHALL, in IDLE with start=1, capture window_len, clear all counters and overflow, and enter ARM next cycle.
REQ-018 SHALL stay in ARM for exactly SYNC_STAGES cycles to flush the synchronizer, then enter MEASURE.
REQ-019 SHALL go from ARM directly to DONE, with all counts zero, when the captured window_len is 0.
REQ-020 SHALL stay in MEASURE for exactly window_len cycles; each cycle, if xs=1, hi_count increments.
REQ-021 SHALL increment edge_count when xs=1 and the previous xs=0. The reference for the first MEASURE cycle is xs from the last ARM cycle.
REQ-022 SHALL saturate each counter at all-ones and set overflow sticky until the next start.
REQ-023 SHALL assert result_valid in DONE; hi_count, edge_count and overflow SHALL then be held stable.
REQ-024 SHALL leave DONE for IDLE on the first cycle where result_valid and result_ready are both 1.
REQ-025 SHALL hold result_valid indefinitely while result_ready=0.
REQ-026 SHALL ignore start outside IDLE, including a start asserted in the same cycle as the DONE handshake.
REQ-027 SHALL change window_len only at capture; changes mid-measurement have no effect.

Reset
REQ-028 SHALL, while sys_rst_n=0 at a clock edge, force IDLE and clear every output, counter and synchronizer flop to 0, at any state including mid-MEASURE.

Configuration
REQ-029 SHALL, with macro XOR_METER_EDGE_CNT_EN defined, implement edge_count per REQ-021/022.
REQ-030 SHALL, without XOR_METER_EDGE_CNT_EN, tie edge_count to 0, leave the edge logic unsynthesized, and let overflow reflect hi_count only.

Structure
REQ-031 SHALL take the FSM state typedef and encodings, and the SYNC_STAGES minimum constant, from shared package xor_meter_pkg.
REQ-032 SHALL instantiate one sub-module, xm_sync: a parameterized N-flop synchronizer with synchronous active-low reset.

Verification
REQ-033 SHALL cover: xor_in held 1, window_len=100 -> hi_count=100, edge_count=0, overflow=0; result_valid exactly 2+100 cycles after the start cycle plus the DONE entry cycle.
REQ-034 SHALL cover: xs low at the last ARM cycle, then toggling every cycle, window_len=10 -> hi_count=5, edge_count=5.
REQ-035 SHALL cover: CNT_W=4, xor_in held 1, window_len=20 -> hi_count=15, overflow=1.
REQ-036 SHALL cover: result_ready low for 5 cycles in DONE, with start pulsed -> result_valid held, counts stable, no new measurement; IDLE one cycle after ready=1.
REQ-037 SHALL cover: sys_rst_n low for 1 cycle mid-MEASURE -> next cycle IDLE, busy=0, all outputs 0; a following start runs normally.
REQ-038 SHALL cover: window_len=0 -> DONE after ARM, hi_count=0, edge_count=0, overflow=0.
